// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Circular increment over 0..n-1.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotate-priority encoder: first asserted request at or after start_ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] start_ptr,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [IDXW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = start_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
            cand = IDXW'(next_idx(int'(cand), NREQ));
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port between NREQ requesters,
// holding each grant for a burst of up to MAX_BURST words.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ARB_IDLE  | no grant active; pick next requester from rr_ptr onwards
//  ARB_BURST | grant_id owns the write port until burst limit or valid drop
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int IDXW      = $clog2(NREQ)
) (
    input  logic                 write_clk,
    input  logic                 write_rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*BITS-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 p_write_full,
    output logic                 p_write_en,
    output logic [BITS-1:0]      p_write_data,
    output logic [IDXW-1:0]      grant_id,
    output logic                 busy
);

    localparam int CNTW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t      state_q;
    arb_state_t      state_d;
    logic [IDXW-1:0] grant_id_q;
    logic [IDXW-1:0] rr_ptr_q;
    logic [CNTW-1:0] burst_cnt_q;

    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic            in_burst;
    logic            granted_valid;
    logic            accept;
    logic            burst_last;
    logic            release_burst;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req       (req_valid),
        .start_ptr (rr_ptr_q),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    assign in_burst      = (state_q == ARB_BURST);
    assign granted_valid = req_valid[grant_id_q];
    assign accept        = in_burst & granted_valid & ~p_write_full;
    assign burst_last    = (burst_cnt_q == CNTW'(MAX_BURST - 1));
    // A dropped valid releases even while full, so a stalled grant never pins the port.
    assign release_burst = in_burst & ((accept & burst_last) | ~granted_valid);

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_BURST;
                end
            end
            ARB_BURST: begin
                if (release_burst) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // All outputs derive from registered state, so async reset clears them at once.
    always_comb begin
        req_ready    = '0;
        p_write_en   = 1'b0;
        p_write_data = '0;
        busy         = 1'b0;
        if (in_burst) begin
            busy                  = 1'b1;
            req_ready[grant_id_q] = ~p_write_full;
            p_write_en            = accept;
            p_write_data          = req_data[grant_id_q*BITS +: BITS];
        end
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_id_q  <= pick_idx;
                        burst_cnt_q <= '0;
                    end
                end
                ARB_BURST: begin
                    if (release_burst) begin
                        rr_ptr_q    <= IDXW'(next_idx(int'(grant_id_q), NREQ));
                        burst_cnt_q <= '0;
                    end else if (accept) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end
                end
                default: begin
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end

    assign grant_id = grant_id_q;

endmodule
